// File: rtl/uart_frame_ctrl_if.sv
// rtl/uart_frame_ctrl_if.sv - FIFO pop side and payload stream bundle for uart_frame_ctrl
interface uart_frame_ctrl_if #(
    parameter int DATA_BITS = 8
);
    logic                 rx_empty;
    logic [DATA_BITS-1:0] rx_data;
    logic                 read_uart;
    logic [DATA_BITS-1:0] pay_data;
    logic                 pay_valid;
    logic                 pay_ready;
    logic                 pay_last;

    // master: receive FIFO plus payload consumer; slave: the frame sequencer
    modport master (
        output rx_empty, rx_data, pay_ready,
        input  read_uart, pay_data, pay_valid, pay_last
    );

    modport slave (
        input  rx_empty, rx_data, pay_ready,
        output read_uart, pay_data, pay_valid, pay_last
    );
endinterface

// File: rtl/uart_frame_ctrl.sv
// rtl/uart_frame_ctrl.sv - drains the UART rx FIFO into SOF/LEN/payload/CSUM frames
// Payload is streamed through; length, checksum and inter-byte timeout are checked.
module uart_frame_ctrl #(
    parameter int                 DATA_BITS   = 8,
    parameter logic [7:0]         SOF         = 8'hAA,
    parameter int                 MAX_LEN     = 16,
    parameter int                 LEN_BITS    = 5,
    parameter int                 TIMEOUT_CYC = 500000,
    parameter int                 TO_BITS     = 19
) (
    input  logic                clk_50MHz,
    input  logic                reset,
    input  logic                enable,
    uart_frame_ctrl_if.slave    bus,
    output logic                frame_ok,
    output logic                frame_err,
    output logic [1:0]          err_code,
    output logic [LEN_BITS-1:0] frame_len,
    output logic                busy
);
    typedef enum logic [1:0] {S_HUNT, S_LEN, S_PAYLOAD, S_CSUM} state_t;

    state_t                 r_state;
    logic [LEN_BITS-1:0]    r_len;
    logic [LEN_BITS-1:0]    r_cnt;
    logic [DATA_BITS-1:0]   r_sum;
    logic [TO_BITS-1:0]     r_to_cnt;
    logic                   r_frame_ok;
    logic                   r_frame_err;
    logic [1:0]             r_err_code;
    logic [LEN_BITS-1:0]    r_frame_len;
    logic                   r_busy;

    logic w_in_pay;
    logic w_avail;
    logic w_pop;
    logic w_last;
    logic w_timeout;
    logic w_len_bad;

    // gated by reset so nothing is popped or offered while held in reset
    assign w_avail   = reset & enable & ~bus.rx_empty;
    assign w_in_pay  = (r_state == S_PAYLOAD);
    assign w_pop     = w_avail & (~w_in_pay | bus.pay_ready);
    assign w_last    = (r_cnt == (r_len - LEN_BITS'(1)));
    assign w_timeout = (r_to_cnt == TO_BITS'(TIMEOUT_CYC - 1));
    assign w_len_bad = (bus.rx_data == '0) || (bus.rx_data > DATA_BITS'(MAX_LEN));

    assign bus.read_uart = w_pop;
    assign bus.pay_valid = w_avail & w_in_pay;
    assign bus.pay_data  = bus.rx_data;
    assign bus.pay_last  = w_avail & w_in_pay & w_last;

    assign frame_ok  = r_frame_ok;
    assign frame_err = r_frame_err;
    assign err_code  = r_err_code;
    assign frame_len = r_frame_len;
    assign busy      = r_busy;

    always_ff @(posedge clk_50MHz or negedge reset) begin
        if (!reset) begin
            r_state     <= S_HUNT;
            r_len       <= '0;
            r_cnt       <= '0;
            r_sum       <= '0;
            r_to_cnt    <= '0;
            r_frame_ok  <= 1'b0;
            r_frame_err <= 1'b0;
            r_err_code  <= 2'b00;
            r_frame_len <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_frame_ok  <= 1'b0;
            r_frame_err <= 1'b0;
            if (r_state == S_HUNT) begin
                r_to_cnt <= '0;
                if (w_pop && (bus.rx_data == SOF)) begin
                    r_state <= S_LEN;
                    r_busy  <= 1'b1;
                end
            end else if (w_pop) begin
                r_to_cnt <= '0;
                case (r_state)
                    S_LEN: begin
                        r_len <= bus.rx_data[LEN_BITS-1:0];
                        r_cnt <= '0;
                        // checksum covers the payload bytes only
                        r_sum <= '0;
                        if (w_len_bad) begin
                            r_frame_err <= 1'b1;
                            r_err_code  <= 2'b01;
                            r_state     <= S_HUNT;
                            r_busy      <= 1'b0;
                        end else begin
                            r_state <= S_PAYLOAD;
                        end
                    end
                    S_PAYLOAD: begin
                        r_sum <= r_sum + bus.rx_data;
                        r_cnt <= r_cnt + LEN_BITS'(1);
                        if (w_last) begin
                            r_state <= S_CSUM;
                        end
                    end
                    S_CSUM: begin
                        r_frame_len <= r_len;
                        if (bus.rx_data == r_sum) begin
                            r_frame_ok <= 1'b1;
                            r_err_code <= 2'b00;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_err_code  <= 2'b10;
                        end
                        r_state <= S_HUNT;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state <= S_HUNT;
                        r_busy  <= 1'b0;
                    end
                endcase
            end else if (w_timeout) begin
                r_frame_err <= 1'b1;
                r_err_code  <= 2'b11;
                r_to_cnt    <= '0;
                r_state     <= S_HUNT;
                r_busy      <= 1'b0;
            end else begin
                r_to_cnt <= r_to_cnt + TO_BITS'(1);
            end
        end
    end
endmodule

// File: tb/tb_uart_frame_ctrl.sv
// tb/tb_uart_frame_ctrl.sv - directed scoreboard bench for uart_frame_ctrl
module tb_uart_frame_ctrl;
    localparam int TO = 40;

    typedef struct {
        logic       ok;
        logic [1:0] code;
        logic [4:0] len;
        int         lat;
    } evt_t;

    typedef struct {
        logic [7:0] d;
        logic       last;
    } pay_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b1;
    logic       frame_ok, frame_err, busy;
    logic [1:0] err_code;
    logic [4:0] frame_len;

    logic [7:0] fifo[$];
    pay_t       exp_pay[$];
    evt_t       exp_evt[$];
    int         n_chk = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         last_pop_cyc = 0;
    int         n_pops = 0;
    int         n0;
    bit         pend_pop = 1'b0;
    bit         bp_mode = 1'b0;
    logic [4:0] m_len = 5'd0;

    always #10 clk = ~clk;

    uart_frame_ctrl_if #(.DATA_BITS(8)) bus ();

    uart_frame_ctrl #(
        .TIMEOUT_CYC (TO),
        .TO_BITS     (6)
    ) dut (
        .clk_50MHz (clk),
        .reset     (rst_n),
        .enable    (en),
        .bus       (bus),
        .frame_ok  (frame_ok),
        .frame_err (frame_err),
        .err_code  (err_code),
        .frame_len (frame_len),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        fifo.push_back(b);
    endtask

    task automatic ep(input logic [7:0] d, input logic last);
        pay_t p;
        p.d = d;
        p.last = last;
        exp_pay.push_back(p);
    endtask

    task automatic ee(input logic ok, input logic [1:0] code, input bit upd,
                      input logic [4:0] len, input int lat);
        evt_t e;
        if (upd) m_len = len;
        e.ok = ok;
        e.code = code;
        e.len = m_len;
        e.lat = lat;
        exp_evt.push_back(e);
    endtask

    // one clock: check registered outputs, advance the FIFO model, drive, sample combinational outputs
    task automatic tick();
        evt_t e;
        pay_t p;
        @(negedge clk);
        cyc++;
        if (frame_ok || frame_err) begin
            if (exp_evt.size() == 0) begin
                chk("spurious_pulse", 32'({frame_ok, frame_err}), 32'd0);
            end else begin
                e = exp_evt.pop_front();
                chk("evt_ok", 32'(frame_ok), 32'(e.ok));
                chk("evt_err", 32'(frame_err), 32'(!e.ok));
                chk("err_code", 32'(err_code), 32'(e.code));
                chk("frame_len", 32'(frame_len), 32'(e.len));
                chk("evt_latency", 32'(cyc - last_pop_cyc), 32'(e.lat));
            end
        end
        if (pend_pop && fifo.size() > 0) void'(fifo.pop_front());
        bus.rx_empty  = (fifo.size() == 0);
        bus.rx_data   = (fifo.size() > 0) ? fifo[0] : 8'h00;
        bus.pay_ready = bp_mode ? (cyc % 2 == 0) : 1'b1;
        #1;
        pend_pop = bus.read_uart;
        if (bus.read_uart) begin
            last_pop_cyc = cyc;
            n_pops++;
        end
        if (bus.rx_empty) chk("empty_no_pop", 32'(bus.read_uart), 32'd0);
        if (bus.pay_valid && !bus.pay_ready) chk("bp_no_pop", 32'(bus.read_uart), 32'd0);
        if (bus.pay_valid && bus.pay_ready) begin
            if (exp_pay.size() == 0) begin
                chk("spurious_pay", 32'(bus.pay_valid), 32'd0);
            end else begin
                p = exp_pay.pop_front();
                chk("pay_data", 32'(bus.pay_data), 32'(p.d));
                chk("pay_last", 32'(bus.pay_last), 32'(p.last));
            end
        end
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((fifo.size() > 0 || exp_evt.size() > 0 || pend_pop) && n < 300) begin
            tick();
            n++;
        end
        chk({tag, "_done"}, 32'(n < 300), 32'd1);
        tick();
        tick();
        chk({tag, "_pay_left"}, 32'(exp_pay.size()), 32'd0);
    endtask

    initial begin
        bus.rx_empty  = 1'b0;
        bus.rx_data   = 8'hAA;
        bus.pay_ready = 1'b1;
        #25;
        chk("rst_read_uart", 32'(bus.read_uart), 32'd0);
        chk("rst_pay_valid", 32'(bus.pay_valid), 32'd0);
        chk("rst_pay_last", 32'(bus.pay_last), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pulses", 32'({frame_ok, frame_err}), 32'd0);
        chk("rst_err_code", 32'(err_code), 32'd0);
        chk("rst_frame_len", 32'(frame_len), 32'd0);
        bus.rx_empty = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;

        // good frame
        n0 = n_pops;
        push(8'hAA); push(8'h03); push(8'h11); push(8'h22); push(8'h33); push(8'h66);
        ep(8'h11, 1'b0); ep(8'h22, 1'b0); ep(8'h33, 1'b1);
        ee(1'b1, 2'b00, 1'b1, 5'd3, 1);
        tick();
        chk("busy_sof_cycle", 32'(busy), 32'd0);
        tick();
        chk("busy_after_sof", 32'(busy), 32'd1);
        drain("good");
        chk("good_pops", 32'(n_pops - n0), 32'd6);
        chk("busy_idle", 32'(busy), 32'd0);

        // bad checksum
        push(8'hAA); push(8'h02); push(8'h10); push(8'h20); push(8'h31);
        ep(8'h10, 1'b0); ep(8'h20, 1'b1);
        ee(1'b0, 2'b10, 1'b1, 5'd2, 1);
        drain("bad_csum");

        // length errors then a recovering frame
        push(8'hAA); push(8'h00);
        ee(1'b0, 2'b01, 1'b0, 5'd0, 1);
        push(8'hAA); push(8'h11);
        ee(1'b0, 2'b01, 1'b0, 5'd0, 1);
        push(8'hAA); push(8'h01); push(8'h5A); push(8'h5A);
        ep(8'h5A, 1'b1);
        ee(1'b1, 2'b00, 1'b1, 5'd1, 1);
        drain("len_err");

        // garbage discarded in HUNT
        push(8'h00); push(8'hFF); push(8'h55);
        push(8'hAA); push(8'h01); push(8'h07); push(8'h07);
        ep(8'h07, 1'b1);
        ee(1'b1, 2'b00, 1'b1, 5'd1, 1);
        drain("garbage");

        // backpressure on payload
        bp_mode = 1'b1;
        push(8'hAA); push(8'h04); push(8'h01); push(8'h02); push(8'h03); push(8'h04); push(8'h0A);
        ep(8'h01, 1'b0); ep(8'h02, 1'b0); ep(8'h03, 1'b0); ep(8'h04, 1'b1);
        ee(1'b1, 2'b00, 1'b1, 5'd4, 1);
        drain("backpressure");
        bp_mode = 1'b0;

        // timeout mid-payload
        push(8'hAA); push(8'h02); push(8'h01);
        ep(8'h01, 1'b0);
        ee(1'b0, 2'b11, 1'b0, 5'd0, TO + 1);
        drain("timeout");
        chk("to_err_code_held", 32'(err_code), 32'd3);

        // reset mid-payload
        push(8'hAA); push(8'h04); push(8'h01); push(8'h02);
        ep(8'h01, 1'b0); ep(8'h02, 1'b0);
        for (int i = 0; i < 20 && exp_pay.size() > 0; i++) tick();
        chk("mid_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        push(8'h03);
        bus.rx_empty = 1'b0;
        bus.rx_data  = 8'h03;
        #1;
        chk("mrst_read_uart", 32'(bus.read_uart), 32'd0);
        chk("mrst_pay_valid", 32'(bus.pay_valid), 32'd0);
        chk("mrst_pay_last", 32'(bus.pay_last), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_pulses", 32'({frame_ok, frame_err}), 32'd0);
        chk("mrst_err_code", 32'(err_code), 32'd0);
        chk("mrst_frame_len", 32'(frame_len), 32'd0);
        fifo.delete();
        exp_pay.delete();
        pend_pop = 1'b0;
        m_len = 5'd0;
        tick(); tick(); tick();
        rst_n = 1'b1;
        for (int i = 0; i < 2 * TO; i++) tick();
        chk("post_rst_busy", 32'(busy), 32'd0);
        push(8'hAA); push(8'h01); push(8'h07); push(8'h07);
        ep(8'h07, 1'b1);
        ee(1'b1, 2'b00, 1'b1, 5'd1, 1);
        drain("post_reset");

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
